trap_unit: RTL and testbench
============================

Name: trap_unit

Overview:
- Machine-mode trap controller; consumes the decode stage's exception/cause/mtval report and the MRET indication.
- Saves trap state into a small CSR file, redirects fetch to the handler or to mepc, and holds pipeline flush for a programmable drain window.
- Sits beside decode/fetch; its redirect and flush outputs drive the fetch PC mux and the pipeline-register flush inputs.

Parameters:
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec (base, mode bits 00).
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect (>=1).
- CNT_W, 2, width of the drain counter; must hold FLUSH_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- exception  in  1  decode reports an illegal instruction this cycle.
- cause  in  5  exception cause code.
- mtval_in  in  32  trap value from decode.
- pc_in  in  32  PC of the reporting instruction (PCD).
- mret  in  1  decoded MRET this cycle.
- csr_addr  in  12  CSR access address.
- csr_we  in  1  CSR write enable.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  CSR read data, combinational from csr_addr.
- redirect  out  1  one-cycle pulse: fetch loads pc_target.
- pc_target  out  32  redirect target.
- flush  out  1  flush all pipeline registers.
- busy  out  1  high whenever state != IDLE.
- mie  out  1  mstatus.MIE.

Behaviour:
- Reset values: all outputs 0.
  - mtvec=MTVEC_RESET; mepc=mcause=mtval=mscratch=0; MIE=0, MPIE=0; state=IDLE; drain counter=0.
- CSR map:
  - mstatus 0x300: MIE bit3, MPIE bit7, other bits read 0.
  - mtvec 0x305; mscratch 0x340; mepc 0x341 (bits[1:0] forced 0 on write); mcause 0x342; mtval 0x343.
  - Unmapped addresses read 0; writes to them are ignored.
- FSM states:
  - IDLE -> TRAP on exception; exception has priority over a simultaneous mret.
  - IDLE -> RET on mret with no exception.
  - TRAP -> DRAIN and RET -> DRAIN unconditionally.
  - DRAIN -> IDLE when the counter reaches FLUSH_CYCLES-1.
- Trap entry, at the edge ending cycle N (IDLE, exception=1):
  - mepc<=pc_in & ~3; mcause<={27'b0,cause}; mtval<=mtval_in; MPIE<=MIE; MIE<=0.
- TRAP, cycle N+1: redirect=1, flush=1, pc_target={mtvec[31:2],2'b00}.
- RET, cycle N+1: redirect=1, flush=1, pc_target=mepc; at the edge, MIE<=MPIE and MPIE<=1.
- DRAIN: flush=1, redirect=0; counter increments each cycle and clears on exit.
- Total flush length = 1 + FLUSH_CYCLES cycles.
- While busy, exception and mret are ignored (the flushed instructions are squashed).
- CSR write in the same cycle as a trap save: the trap save wins for mepc/mcause/mtval/mstatus; writes to other CSRs proceed.
- CSR write in IDLE takes effect at the next edge; csr_rdata shows the old value in the write cycle.
- Reset asserted mid-trap: immediate return to IDLE; all CSRs take reset values; redirect/flush drop asynchronously.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined:
  - mtvec[1:0] is writable.
  - Mode 01 gives trap target = {mtvec[31:2],2'b00} + 4*cause.
  - Mode 00 behaves as direct mode.
- Undefined: mtvec[1:0] is hardwired 00 and the target is always the base.

Decomposition:
- Shared package (alongside the opcode defines): CSR address constants, MSTATUS_MIE_BIT/MSTATUS_MPIE_BIT, cause codes (ILLEGAL_INSTR=2, BREAKPOINT=3, ECALL_M=11), FSM state encoding.
- One natural sub-module, trap_csr_file: the CSR storage plus the read mux.
- The FSM and drain counter stay in trap_unit.

Test Plan:
- Reset, then read 0x305 -> 0x100; reads of 0x300/0x341/0x342/0x343 -> 0.
- Write 0x300=0x8; exception=1, cause=2, mtval_in=0x7F, pc_in=0x40 ->
  - next cycle: redirect=1, pc_target=0x100, flush=1 for 3 cycles;
  - afterwards mepc=0x40, mcause=2, mtval=0x7F, mstatus=0x80.
- From the post-trap state, pulse mret -> redirect=1, pc_target=0x40; mstatus then reads 0x88; busy clears after 3 cycles.
- Simultaneous exception and mret in IDLE -> trap taken with pc_target=mtvec; a second exception during DRAIN leaves mepc/mcause unchanged.
- Write 0x341=0x1237 -> reads 0x1234. Write 0x7C0=5 -> reads 0.
- TRAP_VECTORED_EN defined, mtvec=0x201, cause=2 -> pc_target=0x208. Assert rst during DRAIN -> flush=0 immediately and mtvec=0x100.

Source files
------------

// File: rtl/trap_unit_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR map, mstatus
// bit positions, cause codes and FSM state encoding.
package trap_unit_pkg;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT    = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M       = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRAP  = 2'b01,
    ST_RET   = 2'b10,
    ST_DRAIN = 2'b11
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode trap CSR storage and combinational read mux.
// TRAP_VECTORED_EN makes mtvec[1:0] writable and enables vectored mode 01.
module trap_csr_file
  import trap_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        save_i,
  input  logic [31:0] save_pc_i,
  input  logic [4:0]  save_cause_i,
  input  logic [31:0] save_val_i,
  input  logic        restore_i,
  output logic [31:0] trap_vec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  // Trap save and MRET restore own the trap-state CSRs in their cycle;
  // software writes to those registers are dropped, others still land.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (save_i) begin
        mepc_q   <= {save_pc_i[31:2], 2'b00};
        mcause_q <= {27'b0, save_cause_i};
        mtval_q  <= save_val_i;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (restore_i) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
      if (we_i) begin
        case (addr_i)
          CSR_MSTATUS: if (!save_i && !restore_i) begin
            mie_q  <= wdata_i[MSTATUS_MIE_BIT];
            mpie_q <= wdata_i[MSTATUS_MPIE_BIT];
          end
`ifdef TRAP_VECTORED_EN
          CSR_MTVEC:    mtvec_q <= wdata_i;
`else
          CSR_MTVEC:    mtvec_q <= {wdata_i[31:2], 2'b00};
`endif
          CSR_MSCRATCH: mscratch_q <= wdata_i;
          CSR_MEPC:     if (!save_i) mepc_q <= {wdata_i[31:2], 2'b00};
          CSR_MCAUSE:   if (!save_i) mcause_q <= wdata_i;
          CSR_MTVAL:    if (!save_i) mtval_q <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CSR_MSTATUS: begin
        rdata_o[MSTATUS_MIE_BIT]  = mie_q;
        rdata_o[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MTVEC:    rdata_o = mtvec_q;
      CSR_MSCRATCH: rdata_o = mscratch_q;
      CSR_MEPC:     rdata_o = mepc_q;
      CSR_MCAUSE:   rdata_o = mcause_q;
      CSR_MTVAL:    rdata_o = mtval_q;
      default:      rdata_o = '0;
    endcase
  end

  always_comb begin
    trap_vec_o = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01)
      trap_vec_o = {mtvec_q[31:2], 2'b00} + {25'b0, save_cause_i, 2'b00};
`endif
  end

  assign mepc_o = mepc_q;
  assign mie_o  = mie_q;

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller: trap/MRET sequencing, fetch redirect and
// pipeline flush drain. Optional vectored mtvec via TRAP_VECTORED_EN.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic [4:0]  cause,
  input  logic [31:0] mtval_in,
  input  logic [31:0] pc_in,
  input  logic        mret,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        busy,
  output logic        mie
);

  trap_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             redirect_q, flush_q;
  logic [31:0]      pc_target_q;
  logic [31:0]      trap_vec, mepc;
  logic             take_trap, in_ret;

  assign take_trap = (state_q == ST_IDLE) && exception;
  assign in_ret    = (state_q == ST_RET);

  trap_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
    .clk_i        (clk),
    .rst_i        (rst),
    .addr_i       (csr_addr),
    .we_i         (csr_we),
    .wdata_i      (csr_wdata),
    .rdata_o      (csr_rdata),
    .save_i       (take_trap),
    .save_pc_i    (pc_in),
    .save_cause_i (cause),
    .save_val_i   (mtval_in),
    .restore_i    (in_ret),
    .trap_vec_o   (trap_vec),
    .mepc_o       (mepc),
    .mie_o        (mie)
  );

  // Outputs are registered on the edge entering each state, so the TRAP/RET
  // cycle presents redirect+flush and DRAIN holds flush for FLUSH_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      redirect_q  <= 1'b0;
      flush_q     <= 1'b0;
      pc_target_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exception) begin
            state_q     <= ST_TRAP;
            redirect_q  <= 1'b1;
            flush_q     <= 1'b1;
            pc_target_q <= trap_vec;
          end else if (mret) begin
            state_q     <= ST_RET;
            redirect_q  <= 1'b1;
            flush_q     <= 1'b1;
            pc_target_q <= mepc;
          end
        end
        ST_TRAP, ST_RET: begin
          state_q    <= ST_DRAIN;
          redirect_q <= 1'b0;
          flush_q    <= 1'b1;
          cnt_q      <= '0;
        end
        ST_DRAIN: begin
          if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          redirect_q <= 1'b0;
          flush_q    <= 1'b0;
          cnt_q      <= '0;
        end
      endcase
    end
  end

  assign redirect  = redirect_q;
  assign flush     = flush_q;
  assign pc_target = pc_target_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_unit.sv
// Scoreboard bench for trap_unit: stimulus pushes expected redirect targets,
// flush/busy run lengths and CSR read values; a negedge monitor checks them.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exception = 1'b0;
  logic [4:0]  cause = '0;
  logic [31:0] mtval_in = '0;
  logic [31:0] pc_in = '0;
  logic        mret = 1'b0;
  logic [11:0] csr_addr = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] pc_target;
  logic        flush;
  logic        busy;
  logic        mie;

  int checks = 0;
  int errors = 0;
  logic rd_req = 1'b0;

  logic [31:0] csr_q[$];
  logic [31:0] tgt_q[$];
  int          flen_q[$];
  int          blen_q[$];
  int          frun = 0;
  int          brun = 0;

  trap_unit #(.MTVEC_RESET(32'h0000_0100), .FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .exception(exception), .cause(cause),
    .mtval_in(mtval_in), .pc_in(pc_in), .mret(mret), .csr_addr(csr_addr),
    .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redirect(redirect), .pc_target(pc_target), .flush(flush), .busy(busy),
    .mie(mie)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      frun = 0;
      brun = 0;
    end else begin
      if (rd_req) begin
        if (csr_q.size() > 0) check($sformatf("csr_rdata[%03h]", csr_addr), csr_rdata, csr_q.pop_front());
        else unexpected("csr_rdata");
      end
      if (redirect) begin
        if (tgt_q.size() > 0) check("pc_target", pc_target, tgt_q.pop_front());
        else unexpected("redirect");
      end
      if (flush) frun++;
      else if (frun > 0) begin
        if (flen_q.size() > 0) check("flush_len", 32'(frun), 32'(flen_q.pop_front()));
        else unexpected("flush_len");
        frun = 0;
      end
      if (busy) brun++;
      else if (brun > 0) begin
        if (blen_q.size() > 0) check("busy_len", 32'(brun), 32'(blen_q.pop_front()));
        else unexpected("busy_len");
        brun = 0;
      end
    end
  end

  task automatic csr_read(input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    csr_q.push_back(exp);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic expect_seq(input logic [31:0] tgt);
    tgt_q.push_back(tgt);
    flen_q.push_back(3);
    blen_q.push_back(3);
  endtask

  task automatic pulse(input logic exc, input logic ret, input logic [4:0] c,
                       input logic [31:0] tv, input logic [31:0] pc);
    exception = exc;
    mret      = ret;
    cause     = c;
    mtval_in  = tv;
    pc_in     = pc;
    @(posedge clk); #1;
    exception = 1'b0;
    mret      = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    if (!done) unexpected("busy_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_mie", {31'b0, mie}, 32'h0);
    check("rst_pc_target", pc_target, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    csr_read(12'h305, 32'h100);
    csr_read(12'h300, 32'h0);
    csr_read(12'h341, 32'h0);
    csr_read(12'h342, 32'h0);
    csr_read(12'h343, 32'h0);

    // Basic trap entry.
    csr_write(12'h300, 32'h8);
    check("mie_set", {31'b0, mie}, 32'h1);
    expect_seq(32'h100);
    pulse(1'b1, 1'b0, 5'd2, 32'h7F, 32'h40);
    wait_idle();
    check("mie_after_trap", {31'b0, mie}, 32'h0);
    csr_read(12'h341, 32'h40);
    csr_read(12'h342, 32'h2);
    csr_read(12'h343, 32'h7F);
    csr_read(12'h300, 32'h80);

    // MRET back to mepc.
    expect_seq(32'h40);
    pulse(1'b0, 1'b1, 5'd0, 32'h0, 32'h0);
    wait_idle();
    csr_read(12'h300, 32'h88);
    check("mie_after_mret", {31'b0, mie}, 32'h1);

    // Exception beats simultaneous mret; exception during drain is ignored.
    expect_seq(32'h100);
    pulse(1'b1, 1'b1, 5'd11, 32'h55, 32'h84);
    @(posedge clk); #1;
    exception = 1'b1;
    cause     = 5'd3;
    mtval_in  = 32'h999;
    pc_in     = 32'h200;
    mret      = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    exception = 1'b0;
    mret      = 1'b0;
    wait_idle();
    csr_read(12'h341, 32'h84);
    csr_read(12'h342, 32'd11);
    csr_read(12'h343, 32'h55);
    csr_read(12'h300, 32'h80);

    // Trap save wins over a same-cycle mepc write.
    expect_seq(32'h100);
    csr_addr  = 12'h341;
    csr_wdata = 32'hAAAA0;
    csr_we    = 1'b1;
    pulse(1'b1, 1'b0, 5'd2, 32'h1, 32'h13);
    csr_we = 1'b0;
    wait_idle();
    csr_read(12'h341, 32'h10);
    csr_read(12'h300, 32'h0);

    csr_write(12'h341, 32'h1237);
    csr_read(12'h341, 32'h1234);
    csr_write(12'h7C0, 32'h5);
    csr_read(12'h7C0, 32'h0);
    csr_write(12'h340, 32'hCAFEF00D);
    csr_read(12'h340, 32'hCAFEF00D);
`ifdef TRAP_VECTORED_EN
    csr_write(12'h305, 32'h203);
    csr_read(12'h305, 32'h203);
`else
    csr_write(12'h305, 32'h203);
    csr_read(12'h305, 32'h200);
`endif

    // Vectored target, then reset during drain.
    csr_write(12'h305, 32'h201);
`ifdef TRAP_VECTORED_EN
    tgt_q.push_back(32'h208);
`else
    tgt_q.push_back(32'h200);
`endif
    pulse(1'b1, 1'b0, 5'd2, 32'h0, 32'h80);
    @(posedge clk); #1;
    check("drain_flush", {31'b0, flush}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_flush", {31'b0, flush}, 32'h0);
    check("rst_async_redirect", {31'b0, redirect}, 32'h0);
    check("rst_async_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    csr_read(12'h305, 32'h100);
    csr_read(12'h341, 32'h0);
    csr_read(12'h300, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("csr_q_drained", 32'(csr_q.size()), 32'h0);
    check("tgt_q_drained", 32'(tgt_q.size()), 32'h0);
    check("flen_q_drained", 32'(flen_q.size()), 32'h0);
    check("blen_q_drained", 32'(blen_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
